// File: rtl/usb_phy_frontend.sv
// USB full-speed pin front-end: tri-state tx, D+/D- synchroniser, turnaround mask,
// line-state decode and SE0 bus-reset detect. Define USB_PHY_DETACH_EN for the timed pull-up detach FSM.

module usb_phy_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= {STAGES{RST_VAL}};
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];
endmodule

module usb_phy_frontend #(
  parameter int SYNC_STAGES      = 2,
  parameter int TX_TURNAROUND    = 2,
  parameter int RESET_SE0_CYCLES = 120,
  parameter int DETACH_CYCLES    = 480000
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       usb_p_tx,
  input  logic       usb_n_tx,
  input  logic       usb_tx_en,
  output logic       usb_p_rx,
  output logic       usb_n_rx,
  output logic [1:0] line_state,
  output logic       bus_reset,
  output logic       bus_reset_active,
  input  logic       detach_req,
  output logic       attached,
  output logic       pin_pu,
  inout  wire        pin_usb_p,
  inout  wire        pin_usb_n
);
  localparam int SW = $clog2(RESET_SE0_CYCLES + 1);
  localparam logic [SW-1:0] SE0_MAX  = SW'(RESET_SE0_CYCLES);
  localparam logic [SW-1:0] SE0_LAST = SW'(RESET_SE0_CYCLES - 1);

  assign pin_usb_p = usb_tx_en ? usb_p_tx : 1'bz;
  assign pin_usb_n = usb_tx_en ? usb_n_tx : 1'bz;

  // lane 0 = D+, lane 1 = D-; idle J resets D+ high, D- low
  logic [1:0] pin_in, sync_out;
  assign pin_in = {pin_usb_n, pin_usb_p};

  genvar i;
  generate
    for (i = 0; i < 2; i++) begin : g_sync
      usb_phy_sync #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(i == 0)
      ) u_sync (
        .clk(clk_48mhz),
        .rst(reset),
        .d  (pin_in[i]),
        .q  (sync_out[i])
      );
    end
  endgenerate

  logic mask;
  generate
    if (TX_TURNAROUND > 0) begin : g_ta
      localparam int TW = $clog2(TX_TURNAROUND + 1);
      logic [TW-1:0] tcnt;
      always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset)              tcnt <= '0;
        else if (usb_tx_en)     tcnt <= TW'(TX_TURNAROUND);
        else if (tcnt != '0)    tcnt <= tcnt - 1'b1;
      end
      assign mask = usb_tx_en | (tcnt != '0);
    end else begin : g_nota
      assign mask = usb_tx_en;
    end
  endgenerate

  assign usb_p_rx   = mask ? 1'b1 : sync_out[0];
  assign usb_n_rx   = mask ? 1'b0 : sync_out[1];
  assign line_state = {usb_n_rx, usb_p_rx};

  logic          se0;
  logic [SW-1:0] se0cnt;
  assign se0 = (line_state == 2'b00) && !mask;

  // pulse fires on the single edge where the count reaches the limit; saturation blocks re-pulsing
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      se0cnt           <= '0;
      bus_reset        <= 1'b0;
      bus_reset_active <= 1'b0;
    end else begin
      bus_reset <= se0 && (se0cnt == SE0_LAST);
      if (!se0) begin
        se0cnt           <= '0;
        bus_reset_active <= 1'b0;
      end else begin
        if (se0cnt != SE0_MAX)   se0cnt           <= se0cnt + 1'b1;
        if (se0cnt == SE0_LAST)  bus_reset_active <= 1'b1;
      end
    end
  end

`ifdef USB_PHY_DETACH_EN
  localparam int DW = (DETACH_CYCLES > 1) ? $clog2(DETACH_CYCLES) : 1;

  typedef enum logic {ATTACHED, DETACHING} pu_state_t;
  pu_state_t     state, state_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic          pu_nxt;

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state  <= ATTACHED;
      dcnt   <= '0;
      pin_pu <= 1'b1;
    end else begin
      state  <= state_nxt;
      dcnt   <= dcnt_nxt;
      pin_pu <= pu_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    pu_nxt    = (state == ATTACHED);
    case (state)
      ATTACHED: if (detach_req) begin
        state_nxt = DETACHING;
        dcnt_nxt  = DW'(DETACH_CYCLES - 1);
        pu_nxt    = 1'b0;
      end
      DETACHING: if (dcnt == '0) begin
        state_nxt = ATTACHED;
        pu_nxt    = 1'b1;
      end else begin
        dcnt_nxt  = dcnt - 1'b1;
        pu_nxt    = 1'b0;
      end
      default: state_nxt = ATTACHED;
    endcase
  end

  assign attached = pin_pu;
`else
  localparam int unused_detach_cycles = DETACH_CYCLES;
  logic unused_detach_req;
  assign unused_detach_req = detach_req;
  assign pin_pu   = 1'b1;
  assign attached = 1'b1;
`endif

endmodule

// File: tb/tb_usb_phy_frontend.sv
// Directed self-checking bench for usb_phy_frontend; detach checks follow USB_PHY_DETACH_EN.

module tb_usb_phy_frontend;
  logic       clk_48mhz = 1'b0;
  logic       reset = 1'b1;
  logic       usb_p_tx = 1'b0, usb_n_tx = 1'b0, usb_tx_en = 1'b0;
  logic       detach_req = 1'b0;
  logic       usb_p_rx, usb_n_rx, bus_reset, bus_reset_active, attached, pin_pu;
  logic [1:0] line_state;
  wire        pin_usb_p, pin_usb_n;

  // far-end host driver
  logic drv_en = 1'b1, drv_p = 1'b1, drv_n = 1'b0;
  assign pin_usb_p = drv_en ? drv_p : 1'bz;
  assign pin_usb_n = drv_en ? drv_n : 1'bz;

  int checks = 0;
  int failures = 0;

  usb_phy_frontend #(
    .SYNC_STAGES(2), .TX_TURNAROUND(2), .RESET_SE0_CYCLES(120), .DETACH_CYCLES(16)
  ) dut (
    .clk_48mhz(clk_48mhz), .reset(reset),
    .usb_p_tx(usb_p_tx), .usb_n_tx(usb_n_tx), .usb_tx_en(usb_tx_en),
    .usb_p_rx(usb_p_rx), .usb_n_rx(usb_n_rx), .line_state(line_state),
    .bus_reset(bus_reset), .bus_reset_active(bus_reset_active),
    .detach_req(detach_req), .attached(attached), .pin_pu(pin_pu),
    .pin_usb_p(pin_usb_p), .pin_usb_n(pin_usb_n)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic step(input int n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pins(input logic p, input logic n);
    drv_p = p;
    drv_n = n;
  endtask

  initial begin
    int pulses, at, bad, low;
    logic act121;

    // reset with idle J
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst_p_rx", usb_p_rx, 1);
    chk("rst_n_rx", usb_n_rx, 0);
    chk("rst_line", line_state, 2'b01);
    chk("rst_bus_reset", bus_reset, 0);
    chk("rst_pin_pu", pin_pu, 1);
    chk("rst_attached", attached, 1);

    // K at t -> 10 at t+2; J at t+5 -> 01 at t+7
    pins(1'b0, 1'b1);
    step(1); chk("k_t1", line_state, 2'b01);
    step(1); chk("k_t2", line_state, 2'b10);
    step(3);
    pins(1'b1, 1'b0);
    step(1); chk("j_t6", line_state, 2'b10);
    step(1); chk("j_t7", line_state, 2'b01);

    // turnaround: line is K, core takes the bus driving SE0
    pins(1'b0, 1'b1);
    step(3);
    chk("k_before_tx", line_state, 2'b10);
    drv_en = 1'b0; usb_tx_en = 1'b1; usb_p_tx = 1'b0; usb_n_tx = 1'b0;
    #1;
    chk("mask_same_cycle", line_state, 2'b01);
    chk("tx_pin_p", pin_usb_p, 0);
    chk("tx_pin_n", pin_usb_n, 0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (line_state !== 2'b01) bad++;
    end
    chk("mask_during_tx", bad, 0);
    usb_tx_en = 1'b0; drv_en = 1'b1; pins(1'b0, 1'b0);
    #1;
    chk("ta_cycle1", line_state, 2'b01);
    step(1); chk("ta_cycle2", line_state, 2'b01);
    step(1); chk("ta_se0_3rd", line_state, 2'b00);
    pins(1'b1, 1'b0);
    step(4);
    chk("ta_no_reset", bus_reset_active, 0);

    // 119 SE0 cycles: no bus reset
    pulses = 0;
    pins(1'b0, 1'b0);
    for (int c = 1; c <= 119; c++) begin
      step(1);
      if (bus_reset === 1'b1) pulses++;
    end
    chk("se0_119_line", line_state, 2'b00);
    pins(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (bus_reset === 1'b1) pulses++;
    end
    chk("se0_119_no_pulse", pulses, 0);
    chk("se0_119_inactive", bus_reset_active, 0);

    // 300 SE0 cycles: one pulse, at cycle 122 after pin drive (2 sync + 120)
    pulses = 0; at = 0; act121 = 1'bx;
    pins(1'b0, 1'b0);
    for (int c = 1; c <= 300; c++) begin
      step(1);
      if (c == 121) act121 = bus_reset_active;
      if (bus_reset === 1'b1) begin pulses++; at = c; end
    end
    chk("se0_300_pulses", pulses, 1);
    chk("se0_300_pulse_at", at, 122);
    chk("se0_active_before", act121, 0);
    chk("se0_active_held", bus_reset_active, 1);
    pins(1'b1, 1'b0);
    step(1); chk("active_t301", bus_reset_active, 1);
    step(1); chk("line_j_t302", line_state, 2'b01);
             chk("active_t302", bus_reset_active, 1);
    step(1); chk("active_clear", bus_reset_active, 0);

`ifdef USB_PHY_DETACH_EN
    // detach for exactly 16 cycles; second request at cycle 5 ignored
    detach_req = 1'b1;
    step(1);
    detach_req = 1'b0;
    chk("detach_pu_low", pin_pu, 0);
    chk("detach_attached_low", attached, 0);
    low = 1;
    for (int c = 1; c < 40; c++) begin
      if (c == 5) detach_req = 1'b1;
      step(1);
      detach_req = 1'b0;
      if (pin_pu === 1'b0) low++;
      else break;
    end
    chk("detach_low_cycles", low, 16);
    chk("detach_reattached", attached, 1);
    // reset at cycle 8 of a detach
    detach_req = 1'b1;
    step(1);
    detach_req = 1'b0;
    step(7);
    chk("detach_c8_low", pin_pu, 0);
`else
    for (int k = 0; k < 4; k++) begin
      detach_req = 1'b1;
      step(1);
      detach_req = 1'b0;
      chk("nodetach_pu", pin_pu, 1);
      chk("nodetach_att", attached, 1);
      step(2);
    end
    chk("nodetach_pu_end", pin_pu, 1);
`endif

    // async reset mid-operation; tx path stays live
    reset = 1'b1;
    #1;
    chk("arst_pin_pu", pin_pu, 1);
    chk("arst_attached", attached, 1);
    chk("arst_line", line_state, 2'b01);
    drv_en = 1'b0; usb_tx_en = 1'b1; usb_p_tx = 1'b0; usb_n_tx = 1'b1;
    #1;
    chk("arst_tx_p", pin_usb_p, 0);
    chk("arst_tx_n", pin_usb_n, 1);
    usb_tx_en = 1'b0; drv_en = 1'b1; pins(1'b1, 1'b0);
    step(2);
    reset = 1'b0;
    step(20);
    chk("post_rst_pu", pin_pu, 1);
    chk("post_rst_line", line_state, 2'b01);
    chk("post_rst_bus_reset", bus_reset, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
